debounce: RTL

//  Per-bit debouncer and edge detector for slow, noisy inputs (buttons, switches).

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_ch.sv | 79 +++++++
 rtl/debounce.sv | 36 +++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the per-bit debouncer.
// The optional DEBOUNCE_PULSE_EN build adds rise/fall pulse outputs.
package debounce_pkg;

  typedef enum logic {ST_IDLE, ST_CHECK} deb_state_e;

  // Counter width for a qualification window of n samples; never narrower than 1 bit.
  function automatic int deb_cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single-channel debouncer: qualifies a level change after StableCycles equal samples.
// DEBOUNCE_PULSE_EN adds registered one-cycle rise/fall pulses.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int   StableCycles = 1000,
  parameter logic ResetVal     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic data_i,
`ifdef DEBOUNCE_PULSE_EN
  output logic rise_o,
  output logic fall_o,
`endif
  output logic level_o
);

  localparam int CntWidth = deb_cnt_width(StableCycles);
  localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(StableCycles - 1);

  deb_state_e          state_r;
  logic [CntWidth-1:0] cnt_r;
  logic                level_r;
  logic                rise_r;
  logic                fall_r;

  // Channel FSM: count consecutive samples that differ from the current level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= CntZero;
      level_r <= ResetVal;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (data_i != level_r) begin
            state_r <= ST_CHECK;
            cnt_r   <= CntOne;
          end else begin
            cnt_r <= CntZero;
          end
        end
        ST_CHECK: begin
          if (data_i == level_r) begin
            state_r <= ST_IDLE;
            cnt_r   <= CntZero;
          end else if (cnt_r == CntLast) begin
            // Last qualifying sample: accept the new level and flag the edge.
            level_r <= data_i;
            rise_r  <= data_i;
            fall_r  <= ~data_i;
            state_r <= ST_IDLE;
            cnt_r   <= CntZero;
          end else begin
            cnt_r <= cnt_r + CntOne;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CntZero;
        end
      endcase
    end
  end

  assign level_o = level_r;
`ifdef DEBOUNCE_PULSE_EN
  assign rise_o  = rise_r;
  assign fall_o  = fall_r;
`endif

endmodule

// File: rtl/debounce.sv
// Width-channel debouncer for synchronized slow inputs.
// Define DEBOUNCE_PULSE_EN to expose rise_o/fall_o edge pulses.
module debounce
  import debounce_pkg::*;
#(
  parameter int               Width        = 8,
  parameter int               StableCycles = 1000,
  parameter logic [Width-1:0] ResetVal     = {Width{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] data_i,
`ifdef DEBOUNCE_PULSE_EN
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
`endif
  output logic [Width-1:0] level_o
);

  for (genvar k = 0; k < Width; k++) begin : g_ch
    debounce_ch #(
      .StableCycles (StableCycles),
      .ResetVal     (ResetVal[k])
    ) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .data_i  (data_i[k]),
`ifdef DEBOUNCE_PULSE_EN
      .rise_o  (rise_o[k]),
      .fall_o  (fall_o[k]),
`endif
      .level_o (level_o[k])
    );
  end

endmodule
